dmrs_gold_seq_gen: RTL and testbench

Streaming generator of the length-31 Gold pseudo-random sequence c(n) used by the NB-IoT uplink DMRS chain. It sits directly upstream of the DMRS cover/modulation stage, which forms (1-2c(n))·w(n). Each request is seeded with a 31-bit c_init. After an Nc-step warm-up, the block delivers SEQ_LEN bits one per accepted transfer over a valid/ready handshake. This replaces the consumer's need to hold the whole sequence as a wide bus.

---
 rtl/dmrs_gold_seq_gen_if.sv | 21 ++
 rtl/dmrs_gold_seq_gen.sv | 119 +++++++++++
 tb/tb_dmrs_gold_seq_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmrs_gold_seq_gen_if.sv
// Request/stream bundle between a DMRS Gold sequence generator and its consumer.
// master = requester/consumer side, slave = generator side.
interface dmrs_gold_seq_gen_if;
  logic        start;
  logic [30:0] c_init;
  logic        busy;
  logic        c_valid;
  logic        c_ready;
  logic        c_out;
  logic        done;

  modport master (
    output start, c_init, c_ready,
    input  busy, c_valid, c_out, done
  );

  modport slave (
    input  start, c_init, c_ready,
    output busy, c_valid, c_out, done
  );
endinterface

// File: rtl/dmrs_gold_seq_gen.sv
// Length-31 Gold sequence generator for the NB-IoT uplink DMRS cover stage:
// seeds x1/x2, discards NC warm-up steps, then streams SEQ_LEN bits over valid/ready.
module dmrs_gold_seq_gen #(
  parameter int NC      = 1600,
  parameter int SEQ_LEN = 20480
) (
  input  logic                clk,
  input  logic                reset,
  dmrs_gold_seq_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] WARM_LAST = (NC > 0) ? 16'(NC - 1) : 16'd0;
  localparam logic [19:0] OUT_LAST  = 20'(SEQ_LEN - 1);
  localparam logic [30:0] X1_SEED   = 31'd1;

  state_t      state;
  state_t      state_nxt;
  logic [30:0] x1;
  logic [30:0] x2;
  logic [15:0] warm_cnt;
  logic [19:0] out_cnt;
  logic        accept;
  logic        xfer;
  logic        step;
  logic        warm_end;
  logic        out_end;

  // Bit 0 is the oldest sample; the new bit enters at bit 30.
  function automatic logic [30:0] x1_step(input logic [30:0] s);
    return {s[3] ^ s[0], s[30:1]};
  endfunction

  function automatic logic [30:0] x2_step(input logic [30:0] s);
    return {s[3] ^ s[2] ^ s[1] ^ s[0], s[30:1]};
  endfunction

  assign accept   = (state == IDLE) && bus.start;
  assign xfer     = (state == STREAM) && bus.c_ready;
  assign step     = (state == WARMUP) || xfer;
  assign warm_end = (warm_cnt == WARM_LAST);
  assign out_end  = (out_cnt == OUT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (NC > 0) ? WARMUP : STREAM;
        end
      end
      WARMUP: begin
        if (warm_end) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (bus.c_ready && out_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counters stop being consulted once their terminal compare moves the FSM on,
  // so the increment past the terminal value is harmless.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x1       <= '0;
      x2       <= '0;
      warm_cnt <= '0;
      out_cnt  <= '0;
    end else if (accept) begin
      x1       <= X1_SEED;
      x2       <= bus.c_init;
      warm_cnt <= '0;
      out_cnt  <= '0;
    end else begin
      if (step) begin
        x1 <= x1_step(x1);
        x2 <= x2_step(x2);
      end
      if (state == WARMUP) begin
        warm_cnt <= warm_cnt + 16'd1;
      end
      if (xfer) begin
        out_cnt <= out_cnt + 20'd1;
      end
    end
  end

  always_comb begin
    bus.c_valid = (state == STREAM);
    bus.busy    = (state == WARMUP) || (state == STREAM);
    bus.done    = (state == DONE);
    bus.c_out   = (state == STREAM) && (x1[0] ^ x2[0]);
  end

endmodule

// File: tb/tb_dmrs_gold_seq_gen.sv
// Scoreboard bench: a short NC=0 instance checked against hand-derived bit tables,
// and an NC=1600 instance checked against a recurrence-level golden model.
module tb_dmrs_gold_seq_gen;

  localparam int NA = 0;
  localparam int LA = 64;
  localparam int NB = 1600;
  localparam int LB = 6000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmrs_gold_seq_gen_if ifa ();
  dmrs_gold_seq_gen_if ifb ();

  dmrs_gold_seq_gen #(.NC(NA), .SEQ_LEN(LA)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  dmrs_gold_seq_gen #(.NC(NB), .SEQ_LEN(LB)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  int tot = 0;
  int bad = 0;
  bit q_a[$];
  bit q_b[$];
  int xfer_a = 0;
  int xfer_b = 0;
  bit stall_a = 1'b0;
  bit stall_b = 1'b0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  bit g1 [NB+LB];
  bit g2 [NB+LB];
  bit exp_b [LB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Golden model straight from the sequence recurrences.
  task automatic gen_golden(input logic [30:0] ci);
    for (int i = 0; i < 31; i++) begin
      g1[i] = (i == 0);
      g2[i] = ci[i];
    end
    for (int n = 0; n + 31 < NB + LB; n++) begin
      g1[n+31] = g1[n+3] ^ g1[n];
      g2[n+31] = g2[n+3] ^ g2[n+2] ^ g2[n+1] ^ g2[n];
    end
    for (int n = 0; n < LB; n++) exp_b[n] = g1[n+NB] ^ g2[n+NB];
  endtask

  always @(negedge clk) begin
    if (ifa.c_valid && ifa.c_ready) begin
      if (q_a.size() == 0) begin
        tot++;
        bad++;
        $display("FAIL a_extra_xfer: got c_out=%0b with no expected bit queued", ifa.c_out);
      end else begin
        chk("a_bit", ifa.c_out, q_a.pop_front());
      end
      xfer_a++;
    end
    if (!ifa.c_valid) chk("a_gate", ifa.c_out, 0);
    if (stall_a && ifa.c_valid) chk("a_hold", ifa.c_out, prev_a);
    if (ifa.done) chk("a_done_left", q_a.size(), 0);
    stall_a <= ifa.c_valid && !ifa.c_ready;
    prev_a  <= ifa.c_out;
  end

  always @(negedge clk) begin
    if (ifb.c_valid && ifb.c_ready) begin
      if (q_b.size() == 0) begin
        tot++;
        bad++;
        $display("FAIL b_extra_xfer: got c_out=%0b with no expected bit queued", ifb.c_out);
      end else begin
        chk("b_bit", ifb.c_out, q_b.pop_front());
      end
      xfer_b++;
    end
    if (!ifb.c_valid) chk("b_gate", ifb.c_out, 0);
    if (stall_b && ifb.c_valid) chk("b_hold", ifb.c_out, prev_b);
    if (ifb.done) chk("b_done_left", q_b.size(), 0);
    stall_b <= ifb.c_valid && !ifb.c_ready;
    prev_b  <= ifb.c_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time %0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int lat;
    int base;

    ifa.start = 1'b0; ifa.c_init = '0; ifa.c_ready = 1'b0;
    ifb.start = 1'b0; ifb.c_init = '0; ifb.c_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_busy", ifa.busy, 0);
    chk("rst_a_valid", ifa.c_valid, 0);
    chk("rst_a_out", ifa.c_out, 0);
    chk("rst_a_done", ifa.done, 0);
    chk("rst_b_busy", ifb.busy, 0);
    chk("rst_b_valid", ifb.c_valid, 0);
    chk("rst_b_out", ifb.c_out, 0);
    chk("rst_b_done", ifb.done, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // c_init=0: only x1 contributes; ones at 0, 31, 59, 62.
    for (int n = 0; n < LA; n++) q_a.push_back(n == 0 || n == 31 || n == 59 || n == 62);
    base = xfer_a;
    ifa.c_ready = 1'b1; ifa.c_init = 31'd0; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    chk("a_nc0_valid", ifa.c_valid, 1);
    chk("a_nc0_busy", ifa.busy, 1);
    cyc = 0;
    while (!ifa.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("a_done_cycle", cyc, 64);
    chk("a_done_busy", ifa.busy, 0);
    chk("a_xfer_count", xfer_a - base, LA);
    @(posedge clk); #1;
    chk("a_done_width", ifa.done, 0);
    chk("a_idle_valid", ifa.c_valid, 0);

    // c_init=1: seeds cancel through c(31); x2 ones at 0,31,59..62 leave c ones at 60,61.
    for (int n = 0; n < LA; n++) q_a.push_back(n == 60 || n == 61);
    base = xfer_a;
    ifa.c_init = 31'd1; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0; ifa.c_init = 31'h7FFFFFFF;
    cyc = 0;
    while (!ifa.done && cyc < 400) begin
      ifa.c_ready = (cyc % 3) != 0;
      ifa.start = (cyc == 10);
      @(posedge clk); #1;
      cyc++;
    end
    ifa.start = 1'b0;
    chk("a2_done_seen", ifa.done, 1);
    chk("a2_xfer_count", xfer_a - base, LA);

    // Long run: random ready, stray starts in WARMUP and STREAM.
    gen_golden(31'h1234567);
    for (int n = 0; n < LB; n++) q_b.push_back(exp_b[n]);
    base = xfer_b;
    ifb.c_init = 31'h1234567; ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    cyc = 0; lat = -1;
    while (!ifb.done && cyc < 40000) begin
      ifb.start = (cyc == 700) || (cyc == 1700);
      ifb.c_init = 31'h5A5A5A5;
      ifb.c_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (lat < 0 && ifb.c_valid) lat = cyc;
      if (!ifb.done) chk("b_busy", ifb.busy, 1);
    end
    ifb.start = 1'b0;
    chk("b_latency", lat, NB);
    chk("b_done_seen", ifb.done, 1);
    chk("b_done_busy", ifb.busy, 0);
    chk("b_xfer_count", xfer_b - base, LB);
    chk("b_queue_empty", q_b.size(), 0);
    @(posedge clk); #1;

    // Abort mid-stream after 5000 transfers.
    for (int n = 0; n < 5000; n++) q_b.push_back(exp_b[n]);
    base = xfer_b;
    ifb.c_init = 31'h1234567; ifb.c_ready = 1'b1; ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    cyc = 0;
    while ((xfer_b - base) < 5000 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("r_xfer_reach", xfer_b - base, 5000);
    ifb.c_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("r_busy", ifb.busy, 0);
    chk("r_valid", ifb.c_valid, 0);
    chk("r_out", ifb.c_out, 0);
    chk("r_done", ifb.done, 0);
    reset = 1'b1;
    ifb.c_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("r_no_done", ifb.done, 0);
      chk("r_idle_busy", ifb.busy, 0);
    end
    chk("r_queue_empty", q_b.size(), 0);

    // Fresh start reproduces the full sequence.
    for (int n = 0; n < LB; n++) q_b.push_back(exp_b[n]);
    base = xfer_b;
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    cyc = 0; lat = -1;
    while (!ifb.done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (lat < 0 && ifb.c_valid) lat = cyc;
    end
    chk("f_latency", lat, NB);
    chk("f_done_cycle", cyc, NB + LB);
    chk("f_xfer_count", xfer_b - base, LB);
    chk("f_queue_empty", q_b.size(), 0);
    @(posedge clk); #1;
    chk("f_done_width", ifb.done, 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
